// File: rtl/vx_cache_flush_ctrl.sv
// Per-bank cache maintenance sequencer: init sweep after reset, drain/flush/wait on request.
// Optional perf counters are enabled by defining CACHE_FLUSH_PERF_EN.
module vx_cache_flush_ctrl #(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 16,
    parameter int NUM_BANKS  = 1,
    parameter int NUM_WAYS   = 1,
    parameter int WRITEBACK  = 0,
    localparam int LINES_PER_BANK = CACHE_SIZE / (LINE_SIZE * NUM_BANKS),
    localparam int LINE_SEL_BITS  = $clog2(LINES_PER_BANK),
    localparam int WAY_SEL_WIDTH  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_begin_valid,
    output logic                     flush_begin_ready,
    output logic                     flush_end_valid,
    input  logic                     flush_end_ready,
    input  logic                     pipe_empty,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic                     op_init,
    output logic                     op_flush,
    output logic [LINE_SEL_BITS-1:0] op_line_idx,
    output logic [WAY_SEL_WIDTH-1:0] op_way_idx,
    output logic                     busy
`ifdef CACHE_FLUSH_PERF_EN
    ,
    output logic [31:0]              perf_flush_cycles,
    output logic [15:0]              perf_flush_count
`endif
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Ways are walked one by one only when evicted data must be read out.
    localparam bit WAY_ITER = (WRITEBACK != 0) && (NUM_WAYS > 1);

    state_t                   state, state_d;
    logic [LINE_SEL_BITS-1:0] line_cnt, line_d;
    logic [WAY_SEL_WIDTH-1:0] way_cnt, way_d;
    logic                     line_last, way_last;

    assign line_last = (line_cnt == LINE_SEL_BITS'(LINES_PER_BANK - 1));
    assign way_last  = (way_cnt == WAY_SEL_WIDTH'(NUM_WAYS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_INIT;
            line_cnt <= '0;
            way_cnt  <= '0;
        end else begin
            state    <= state_d;
            line_cnt <= line_d;
            way_cnt  <= way_d;
        end
    end

    always_comb begin
        state_d = state;
        line_d  = line_cnt;
        way_d   = way_cnt;
        unique case (state)
            ST_INIT: begin
                if (op_ready) begin
                    if (line_last) begin
                        line_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        line_d = line_cnt + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (flush_begin_valid) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pipe_empty) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (op_ready) begin
                    if (WAY_ITER && !way_last) begin
                        way_d = way_cnt + 1'b1;
                    end else begin
                        way_d = '0;
                        if (line_last) begin
                            line_d  = '0;
                            state_d = ST_WAIT;
                        end else begin
                            line_d = line_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (pipe_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (flush_end_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs depend on registered state only, never on inputs.
    always_comb begin
        op_valid          = 1'b0;
        op_init           = 1'b0;
        op_flush          = 1'b0;
        flush_begin_ready = 1'b0;
        flush_end_valid   = 1'b0;
        busy              = 1'b1;
        unique case (state)
            ST_INIT: begin
                op_valid = 1'b1;
                op_init  = 1'b1;
            end
            ST_IDLE: begin
                flush_begin_ready = 1'b1;
                busy              = 1'b0;
            end
            ST_FLUSH: begin
                op_valid = 1'b1;
                op_flush = 1'b1;
            end
            ST_DONE: flush_end_valid = 1'b1;
            default: ;
        endcase
    end

    assign op_line_idx = line_cnt;
    assign op_way_idx  = way_cnt;

`ifdef CACHE_FLUSH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_flush_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (state == ST_IDLE && flush_begin_valid) begin
                perf_flush_cycles <= '0;
            end else if (state != ST_IDLE && state != ST_INIT
                         && perf_flush_cycles != '1) begin
                perf_flush_cycles <= perf_flush_cycles + 1'b1;
            end
            if (state == ST_DONE && flush_end_ready) begin
                perf_flush_count <= perf_flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// Randomized self-checking bench for vx_cache_flush_ctrl (2-way, writeback build).
// Expected op streams come from nested line/way loops; timing from cycle arithmetic.
module tb_vx_cache_flush_ctrl;

    localparam int LINES = 1024 / 16;
    localparam int WAYS  = 2;
    localparam int NOPS  = LINES * WAYS;

    logic       clk;
    logic       reset;
    logic       flush_begin_valid;
    logic       flush_begin_ready;
    logic       flush_end_valid;
    logic       flush_end_ready;
    logic       pipe_empty;
    logic       op_valid;
    logic       op_ready;
    logic       op_init;
    logic       op_flush;
    logic [5:0] op_line_idx;
    logic [0:0] op_way_idx;
    logic       busy;
`ifdef CACHE_FLUSH_PERF_EN
    logic [31:0] perf_flush_cycles;
    logic [15:0] perf_flush_count;
`endif

    int errors = 0;
    int checks = 0;
    int flush_done = 0;

    vx_cache_flush_ctrl #(
        .CACHE_SIZE(1024),
        .LINE_SIZE (16),
        .NUM_BANKS (1),
        .NUM_WAYS  (WAYS),
        .WRITEBACK (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_begin_valid(flush_begin_valid),
        .flush_begin_ready(flush_begin_ready),
        .flush_end_valid  (flush_end_valid),
        .flush_end_ready  (flush_end_ready),
        .pipe_empty       (pipe_empty),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_init          (op_init),
        .op_flush         (op_flush),
        .op_line_idx      (op_line_idx),
        .op_way_idx       (op_way_idx),
        .busy             (busy)
`ifdef CACHE_FLUSH_PERF_EN
        ,
        .perf_flush_cycles(perf_flush_cycles),
        .perf_flush_count (perf_flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        op_ready          = 1'b0;
        flush_begin_valid = 1'b0;
        flush_end_ready   = 1'b0;
        step();
        step();
        reset      = 1'b1;
        flush_done = 0;
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        op_ready          = 1'b0;
        flush_begin_valid = 1'b0;
        flush_end_ready   = 1'b0;
        pipe_empty        = 1'b1;
        step();
        step();
        checks++;
        if ({op_valid, op_init, op_flush, busy, flush_begin_ready, flush_end_valid} !== 6'b110100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 110100",
                     {op_valid, op_init, op_flush, busy, flush_begin_ready, flush_end_valid});
        end
        checks++;
        if (op_line_idx !== 6'd0 || op_way_idx !== 1'b0) begin
            errors++;
            $display("FAIL reset_idx: got line=%0d way=%0d want 0/0", op_line_idx, op_way_idx);
        end
`ifdef CACHE_FLUSH_PERF_EN
        checks++;
        if (perf_flush_cycles !== 32'd0 || perf_flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_flush_cycles, perf_flush_count);
        end
`endif
    endtask

    task automatic test_init_full();
        do_reset();
        op_ready = 1'b1;
        for (int i = 0; i < LINES; i++) begin
            checks++;
            if (!(op_valid === 1'b1 && op_init === 1'b1 && busy === 1'b1
                  && int'(op_line_idx) == i && flush_begin_ready === 1'b0)) begin
                errors++;
                $display("FAIL init_seq: cycle %0d got valid=%b init=%b line=%0d want 1/1/%0d",
                         i + 1, op_valid, op_init, op_line_idx, i);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || flush_begin_ready !== 1'b1 || op_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_done: got busy=%b ready=%b valid=%b want 0/1/0",
                     busy, flush_begin_ready, op_valid);
        end
        op_ready = 1'b0;
    endtask

    task automatic test_init_stall();
        int exp_q[$];
        int acc;
        int guard;
        int prev_line;
        bit stalled;
        do_reset();
        for (int i = 0; i < LINES; i++) exp_q.push_back(i);
        acc = 0;
        guard = 0;
        stalled = 1'b0;
        prev_line = 0;
        while (busy === 1'b1 && guard < 1000) begin
            op_ready = guard[0];
            checks++;
            if (flush_begin_ready !== 1'b0) begin
                errors++;
                $display("FAIL init_begin_ready: got %b want 0", flush_begin_ready);
            end
            if (op_valid === 1'b1) begin
                checks++;
                if (stalled && int'(op_line_idx) != prev_line) begin
                    errors++;
                    $display("FAIL init_stable: got line=%0d want %0d", op_line_idx, prev_line);
                end
                checks++;
                if (exp_q.size() == 0 || op_init !== 1'b1 || int'(op_line_idx) != exp_q[0]) begin
                    errors++;
                    $display("FAIL init_stall_line: got %0d want %0d", op_line_idx,
                             exp_q.size() ? exp_q[0] : -1);
                end
                prev_line = int'(op_line_idx);
                stalled = !op_ready;
                if (op_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    acc++;
                end
            end
            step();
            guard++;
        end
        op_ready = 1'b0;
        checks++;
        if (acc != LINES || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL init_stall_count: got acc=%0d left=%0d busy=%b want %0d/0/0",
                     acc, exp_q.size(), busy, LINES);
        end
    endtask

    task automatic test_flush(input int d, input int h, input int e, input bit rnd);
        int exp_l[$];
        int exp_w[$];
        int span;
        int stalls;
        int guard;
        int want;
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WAYS; w++) begin
                exp_l.push_back(l);
                exp_w.push_back(w);
            end
        checks++;
        if (flush_begin_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_ready: got %b want 1", flush_begin_ready);
        end
        flush_begin_valid = 1'b1;
        flush_end_ready   = 1'b0;
        op_ready          = 1'b0;
        pipe_empty        = (d == 0);
        step();
        span = 0;
        flush_begin_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || flush_begin_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept: got busy=%b ready=%b want 1/0", busy, flush_begin_ready);
        end
        for (int i = 0; i < d; i++) begin
            pipe_empty = 1'b0;
            checks++;
            if (op_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_no_op: got op_valid=%b want 0", op_valid);
            end
            step();
            span++;
        end
        pipe_empty = 1'b1;
        stalls = 0;
        guard = 0;
        while (exp_l.size() > 0 && guard < 5000) begin
            op_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (op_valid === 1'b1) begin
                checks++;
                if (op_flush !== 1'b1 || op_init !== 1'b0
                    || int'(op_line_idx) != exp_l[0] || int'(op_way_idx) != exp_w[0]) begin
                    errors++;
                    $display("FAIL flush_op: got line=%0d way=%0d flush=%b want %0d/%0d/1",
                             op_line_idx, op_way_idx, op_flush, exp_l[0], exp_w[0]);
                end
                if (op_ready) begin
                    void'(exp_l.pop_front());
                    void'(exp_w.pop_front());
                    if (exp_l.size() == 0) pipe_empty = (h == 0);
                end else begin
                    stalls++;
                end
            end
            step();
            span++;
            guard++;
        end
        op_ready = 1'b0;
        checks++;
        if (exp_l.size() != 0) begin
            errors++;
            $display("FAIL flush_timeout: got %0d ops left want 0", exp_l.size());
        end
        for (int i = 0; i < h; i++) begin
            checks++;
            if (flush_end_valid !== 1'b0 || op_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold: got end=%b op=%b want 0/0", flush_end_valid, op_valid);
            end
            step();
            span++;
        end
        pipe_empty = 1'b1;
        checks++;
        if (flush_end_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_early_end: got %b want 0", flush_end_valid);
        end
        step();
        span++;
        checks++;
        if (flush_end_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_valid: got %b want 1", flush_end_valid);
        end
        for (int i = 0; i < e; i++) begin
            step();
            span++;
            checks++;
            if (flush_end_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: got end=%b busy=%b want 1/1", flush_end_valid, busy);
            end
        end
        flush_end_ready = 1'b1;
        step();
        span++;
        flush_end_ready = 1'b0;
        flush_done++;
        checks++;
        if (flush_end_valid !== 1'b0 || flush_begin_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_to_idle: got end=%b ready=%b busy=%b want 0/1/0",
                     flush_end_valid, flush_begin_ready, busy);
        end
        want = (d + 1) + NOPS + stalls + (h + 1) + (e + 1);
        checks++;
        if (span != want) begin
            errors++;
            $display("FAIL flush_span: got %0d want %0d", span, want);
        end
`ifdef CACHE_FLUSH_PERF_EN
        step();
        checks++;
        if (perf_flush_cycles !== 32'(want) || perf_flush_count !== 16'(flush_done)) begin
            errors++;
            $display("FAIL perf: got cycles=%0d count=%0d want %0d/%0d",
                     perf_flush_cycles, perf_flush_count, want, flush_done);
        end
`endif
    endtask

    task automatic test_reset_mid_flush();
        int guard;
        bit saw_end;
        pipe_empty = 1'b1;
        flush_begin_valid = 1'b1;
        step();
        flush_begin_valid = 1'b0;
        op_ready = 1'b1;
        guard = 0;
        while (!(op_valid === 1'b1 && op_line_idx == 6'd20) && guard < 1000) begin
            step();
            guard++;
        end
        checks++;
        if (op_line_idx !== 6'd20 || op_flush !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach: got line=%0d flush=%b want 20/1", op_line_idx, op_flush);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        flush_done = 0;
        checks++;
        if (op_valid !== 1'b1 || op_init !== 1'b1 || op_flush !== 1'b0
            || op_line_idx !== 6'd0 || op_way_idx !== 1'b0 || flush_end_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_init: got v=%b i=%b f=%b line=%0d way=%0d want 1/1/0/0/0",
                     op_valid, op_init, op_flush, op_line_idx, op_way_idx);
        end
        saw_end = 1'b0;
        guard = 0;
        while ((busy === 1'b1 || guard < LINES + 10) && guard < 300) begin
            if (flush_end_valid !== 1'b0) saw_end = 1'b1;
            step();
            guard++;
        end
        op_ready = 1'b0;
        checks++;
        if (saw_end || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_end: got saw_end=%b busy=%b want 0/0", saw_end, busy);
        end
    endtask

    initial begin
        reset             = 1'b0;
        flush_begin_valid = 1'b0;
        flush_end_ready   = 1'b0;
        pipe_empty        = 1'b1;
        op_ready          = 1'b0;
        test_reset();
        test_init_full();
        test_flush(0, 0, 0, 1'b0);
        test_flush(10, 5, 3, 1'b1);
        test_init_stall();
        test_reset_mid_flush();
        test_flush(2, 1, 1, 1'b1);
        test_flush($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
